// File: rtl/branch_resolve_bht.sv
// Branch resolve unit with a direct-mapped table of 2-bit saturating counters.
// Fetch reads a prediction, execute resolves the branch, trains the table and flags mispredicts.
module branch_resolve_bht #(
    parameter int PC_W  = 32,
    parameter int IDX_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] f_pc,
    output logic            f_pred_taken,
    input  logic            x_valid,
    input  logic [PC_W-1:0] x_pc,
    input  logic [2:0]      x_funct3,
    input  logic            x_pred_taken,
    input  logic [PC_W-1:0] x_target,
    output logic            BrUn,
    input  logic            BrEq,
    input  logic            BrLt,
    output logic            x_taken,
    output logic            redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic [31:0]     br_count,
    output logic [31:0]     mispred_count
);
    localparam int ENTRIES = 2 ** IDX_W;

    logic [1:0]       ctr [ENTRIES];
    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] x_idx;
    logic             legal;
    logic             outcome;
    logic             accept;
    logic             mispredict;
    logic [PC_W-1:0]  fix_pc;
    logic             unused_pc_bits;

    assign f_idx          = f_pc[IDX_W+1:2];
    assign x_idx          = x_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{f_pc[PC_W-1:IDX_W+2], f_pc[1:0]};

    // Read without bypass: an update in this cycle only shows up next cycle.
    assign f_pred_taken = ctr[f_idx][1];
    assign BrUn         = x_funct3[1];

    always_comb begin
        outcome = 1'b0;
        legal   = 1'b1;
        case (x_funct3)
            3'b000:  outcome = BrEq;
            3'b001:  outcome = ~BrEq;
            3'b100:  outcome = BrLt;
            3'b101:  outcome = ~BrLt;
            3'b110:  outcome = BrLt;
            3'b111:  outcome = ~BrLt;
            default: legal   = 1'b0;
        endcase
    end

    // Anything in execute during the redirect cycle is on the wrong path.
    assign accept     = x_valid & legal & ~redirect;
    assign x_taken    = accept & outcome;
    assign mispredict = accept & (x_taken != x_pred_taken);
    assign fix_pc     = x_taken ? x_target : x_pc + PC_W'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= 2'b01;
            end
            redirect      <= 1'b0;
            redirect_pc   <= '0;
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            redirect <= mispredict;
            if (accept) begin
                br_count <= br_count + 32'd1;
                if (x_taken) begin
                    if (ctr[x_idx] != 2'b11) begin
                        ctr[x_idx] <= ctr[x_idx] + 2'd1;
                    end
                end else if (ctr[x_idx] != 2'b00) begin
                    ctr[x_idx] <= ctr[x_idx] - 2'd1;
                end
            end
            if (mispredict) begin
                mispred_count <= mispred_count + 32'd1;
                redirect_pc   <= fix_pc;
            end
        end
    end
endmodule
